// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit multiplexed 7-segment display path.
// Glyphs are active-low, written g..a (bit6..bit0).
package seg7_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [3:0] AN_MAG  = 4'b1110;
    localparam logic [3:0] AN_SIGN = 4'b1101;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Sign/magnitude pair is representable in 4-bit two's complement.
    function automatic logic frame_legal(input logic [3:0] mag, input logic minus);
        if (minus)
            return (mag >= 4'd1) && (mag <= 4'd8);
        else
            return mag <= 4'd7;
    endfunction

    function automatic logic [3:0] frame_value(input logic [3:0] mag, input logic minus);
        return minus ? (~mag + 4'd1) : mag;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph lookup: magnitude table for the magnitude digit,
// minus/blank for the sign digit. Anything else is reported illegal.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] glyph,
    input  logic       is_sign,
    output logic       legal,
    output logic [3:0] mag,
    output logic       is_minus
);

    always_comb begin
        legal    = 1'b0;
        mag      = 4'd0;
        is_minus = 1'b0;
        if (is_sign) begin
            case (glyph)
                GLYPH_MINUS: begin
                    legal    = 1'b1;
                    is_minus = 1'b1;
                end
                GLYPH_BLANK: legal = 1'b1;
                default:     legal = 1'b0;
            endcase
        end else begin
            legal = 1'b1;
            case (glyph)
                GLYPH_0: mag = 4'd0;
                GLYPH_1: mag = 4'd1;
                GLYPH_2: mag = 4'd2;
                GLYPH_3: mag = 4'd3;
                GLYPH_4: mag = 4'd4;
                GLYPH_5: mag = 4'd5;
                GLYPH_6: mag = 4'd6;
                GLYPH_7: mag = 4'd7;
                GLYPH_8: mag = 4'd8;
                default: legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/seg7_decoder.sv
// Receive side of the multiplexed 7-segment driver: synchronizes seg/an,
// captures each digit after a stable dwell and rebuilds the signed value.
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE  = 16,
    parameter logic [31:0] TIMEOUT = 32'd4000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [3:0] value,
    output logic       value_valid,
    output logic       err,
    output logic       stale
);

    logic [6:0] seg_m, seg_s;
    logic [3:0] an_m, an_s, an_q;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       capture;

    logic       changed, is_digit, an_bad_evt;

    logic       g_legal, g_minus;
    logic [3:0] g_mag;

    logic       have_mag, have_sign, have_mag_nxt, have_sign_nxt;
    logic [3:0] mag_q, mag_nxt;
    logic       minus_q, minus_nxt;
    logic [3:0] value_nxt;
    logic       valid_nxt, err_nxt;

    logic [31:0] tmo_cnt;

    // Lines idle high, so the synchronizer resets to all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '1;
            seg_s <= '1;
            an_m  <= '1;
            an_s  <= '1;
            an_q  <= '1;
        end else begin
            seg_m <= seg;
            seg_s <= seg_m;
            an_m  <= an;
            an_s  <= an_m;
            an_q  <= an_s;
        end
    end

    assign changed    = (an_s != an_q);
    assign is_digit   = (an_s == AN_MAG) || (an_s == AN_SIGN);
    assign an_bad_evt = changed && !is_digit && (an_s != AN_OFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT:
                if (is_digit) state_nxt = ST_SETTLE;
            ST_SETTLE:
                if (changed)                 state_nxt = is_digit ? ST_SETTLE : ST_WAIT;
                else if (cnt == 8'(SETTLE))  state_nxt = ST_HOLD;
            ST_HOLD:
                if (changed) state_nxt = is_digit ? ST_SETTLE : ST_WAIT;
            default:
                state_nxt = ST_WAIT;
        endcase
    end

    // The first cycle a digit code is seen counts as 1; a capture fires once
    // the code has been unchanged for SETTLE further cycles.
    always_comb begin
        capture = (state == ST_SETTLE) && !changed && (cnt == 8'(SETTLE));
        cnt_nxt = 8'd0;
        if (state_nxt == ST_SETTLE) begin
            if (state != ST_SETTLE || changed)
                cnt_nxt = 8'd1;
            else
                cnt_nxt = cnt + 8'd1;
        end
    end

    seg7_glyph_decode u_glyph (
        .glyph    (seg_s),
        .is_sign  (an_s == AN_SIGN),
        .legal    (g_legal),
        .mag      (g_mag),
        .is_minus (g_minus)
    );

    always_comb begin
        have_mag_nxt  = have_mag;
        have_sign_nxt = have_sign;
        mag_nxt       = mag_q;
        minus_nxt     = minus_q;
        value_nxt     = value;
        valid_nxt     = 1'b0;
        err_nxt       = 1'b0;
        if (an_bad_evt) begin
            err_nxt       = 1'b1;
            have_mag_nxt  = 1'b0;
            have_sign_nxt = 1'b0;
        end else if (capture) begin
            if (!g_legal) begin
                err_nxt       = 1'b1;
                have_mag_nxt  = 1'b0;
                have_sign_nxt = 1'b0;
            end else begin
                if (an_s == AN_SIGN) begin
                    minus_nxt     = g_minus;
                    have_sign_nxt = 1'b1;
                end else begin
                    mag_nxt      = g_mag;
                    have_mag_nxt = 1'b1;
                end
                if (have_mag_nxt && have_sign_nxt) begin
                    have_mag_nxt  = 1'b0;
                    have_sign_nxt = 1'b0;
                    if (frame_legal(mag_nxt, minus_nxt)) begin
                        valid_nxt = 1'b1;
                        value_nxt = frame_value(mag_nxt, minus_nxt);
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_mag    <= 1'b0;
            have_sign   <= 1'b0;
            mag_q       <= 4'd0;
            minus_q     <= 1'b0;
            value       <= 4'd0;
            value_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            have_mag    <= have_mag_nxt;
            have_sign   <= have_sign_nxt;
            mag_q       <= mag_nxt;
            minus_q     <= minus_nxt;
            value       <= value_nxt;
            value_valid <= valid_nxt;
            err         <= err_nxt;
        end
    end

    // Saturating frame watchdog; stale rises on the edge the count hits TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= 32'd0;
            stale   <= 1'b0;
        end else if (value_valid) begin
            tmo_cnt <= 32'd0;
            stale   <= 1'b0;
        end else if (tmo_cnt < TIMEOUT) begin
            tmo_cnt <= tmo_cnt + 32'd1;
            if (tmo_cnt + 32'd1 == TIMEOUT)
                stale <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seg7_decoder.sv
// Bench for seg7_decoder: directed frame table, multi-cycle corner sequences,
// and random anode dwells scored against a dwell-level reference model.
module tb_seg7_decoder;

    localparam int SETTLE  = 16;
    localparam int TIMEOUT = 1000;

    localparam logic [3:0] A_MAG  = 4'b1110;
    localparam logic [3:0] A_SIGN = 4'b1101;
    localparam logic [3:0] A_OFF  = 4'b1111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg = 7'h7F;
    logic [3:0] an = 4'hF;
    logic [3:0] value;
    logic       value_valid, err, stale;

    seg7_decoder #(.SETTLE(SETTLE), .TIMEOUT(32'(TIMEOUT))) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .value_valid (value_valid),
        .err         (err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [3:0] val;
    } ev_t;

    typedef struct {
        logic [6:0] mag_g;
        logic [6:0] sign_g;
        bit         exp_err;
        logic [3:0] exp_val;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_vv = 0;
    ev_t  obs[$];
    ev_t  exp_q[$];
    logic [6:0] mag_tab [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && (value_valid || err)) begin
            chk("pulse_exclusive", {31'd0, value_valid && err}, 32'd0);
            obs.push_back('{is_err: err, val: value});
            if (value_valid) last_vv <= cyc;
        end
    end

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int dur);
        an  = a;
        seg = s;
        repeat (dur) @(negedge clk);
    endtask

    task automatic check_next(input string name, input bit e_err, input logic [3:0] e_val);
        ev_t o;
        if (obs.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no pulse seen, expected err=%0d value=%0h", name, e_err, e_val);
        end else begin
            o = obs.pop_front();
            chk({name, "_kind"}, {31'd0, o.is_err}, {31'd0, e_err});
            chk({name, "_value"}, {28'd0, o.val}, {28'd0, e_val});
        end
    endtask

    task automatic check_none(input string name);
        chk({name, "_no_extra"}, obs.size(), 0);
        obs.delete();
    endtask

    task automatic frame(input logic [6:0] mg, input logic [6:0] sg);
        dwell(A_MAG, mg, 40);
        dwell(A_SIGN, sg, 40);
        dwell(A_OFF, 7'h7F, 20);
    endtask

    // Reference: magnitude lookup, -1 if not a digit glyph.
    function automatic int mag_of(input logic [6:0] g);
        for (int k = 0; k < 9; k++)
            if (mag_tab[k] == g) return k;
        return -1;
    endfunction

    initial begin
        vec_t vt[9];
        logic [3:0] cur_val;
        bit m_hm, m_hs, m_minus;
        int m_mag;
        logic [3:0] prev_code, code;
        logic [6:0] g;
        int dur, r, m;

        mag_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000};

        vt[0] = '{7'b0100100, 7'b1111111, 1'b0, 4'h2};
        vt[1] = '{7'b0000000, 7'b0111111, 1'b0, 4'h8};
        vt[2] = '{7'b1111001, 7'b0111111, 1'b0, 4'hF};
        vt[3] = '{7'b1000000, 7'b0111111, 1'b1, 4'hF};
        vt[4] = '{7'b0000000, 7'b1111111, 1'b1, 4'hF};
        vt[5] = '{7'b0011001, 7'b1111111, 1'b0, 4'h4};
        vt[6] = '{7'b0000010, 7'b0111111, 1'b0, 4'hA};
        vt[7] = '{7'b1111000, 7'b0110111, 1'b1, 4'hA};
        vt[8] = '{7'b0110000, 7'b1111111, 1'b0, 4'h3};

        repeat (3) @(negedge clk);
        chk("reset_value", {28'd0, value}, 32'd0);
        chk("reset_valid", {31'd0, value_valid}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_stale", {31'd0, stale}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Long 100-cycle alternation, two full frames of +2.
        for (int k = 0; k < 2; k++) begin
            dwell(A_MAG, 7'b0100100, 100);
            dwell(A_SIGN, 7'b1111111, 100);
        end
        dwell(A_OFF, 7'h7F, 20);
        check_next("alt_frame0", 1'b0, 4'h2);
        check_next("alt_frame1", 1'b0, 4'h2);
        check_none("alt");

        foreach (vt[i]) begin
            frame(vt[i].mag_g, vt[i].sign_g);
            check_next($sformatf("vec%0d", i), vt[i].exp_err, vt[i].exp_val);
            check_none($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_hold", i), {28'd0, value}, {28'd0, vt[i].exp_val});
        end

        // Illegal anode discards the captured 5; the later -2 frame stands alone.
        dwell(A_MAG, 7'b0010010, 40);
        dwell(4'b1100, 7'h7F, 5);
        dwell(A_SIGN, 7'b0111111, 40);
        dwell(A_MAG, 7'b0100100, 40);
        dwell(A_OFF, 7'h7F, 20);
        check_next("bad_anode_err", 1'b1, 4'h3);
        check_next("bad_anode_next", 1'b0, 4'hE);
        check_none("bad_anode");

        // Short dwells never capture; then let the display stall.
        for (int k = 0; k < 6; k++) begin
            dwell(A_MAG, 7'b0100100, 10);
            dwell(A_SIGN, 7'b0111111, 10);
        end
        dwell(A_OFF, 7'h7F, 1);
        check_none("short_dwell");
        while (cyc < last_vv + TIMEOUT - 2) @(negedge clk);
        chk("stale_before", {31'd0, stale}, 32'd0);
        while (cyc < last_vv + TIMEOUT + 2) @(negedge clk);
        chk("stale_after", {31'd0, stale}, 32'd1);
        frame(7'b1111001, 7'b1111111);
        check_next("stale_recover", 1'b0, 4'h1);
        chk("stale_cleared", {31'd0, stale}, 32'd0);

        // Reset mid-frame: the sign alone must not complete anything.
        dwell(A_MAG, 7'b1111000, 40);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset_value", {28'd0, value}, 32'd0);
        rst_n = 1'b1;
        obs.delete();
        dwell(A_SIGN, 7'b1111111, 40);
        dwell(A_OFF, 7'h7F, 20);
        check_none("midreset_sign_only");
        chk("midreset_keep", {28'd0, value}, 32'd0);
        dwell(A_MAG, 7'b1111000, 40);
        dwell(A_OFF, 7'h7F, 20);
        check_next("midreset_recapture", 1'b0, 4'h7);
        check_none("midreset");
        cur_val = 4'h7;

        // Random dwells against a dwell-level model.
        m_hm = 0; m_hs = 0; m_minus = 0; m_mag = 0;
        prev_code = A_OFF;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      code = A_MAG;
            else if (r <= 6) code = A_SIGN;
            else if (r <= 8) code = A_OFF;
            else begin
                do code = 4'($urandom_range(0, 15));
                while (code == A_MAG || code == A_SIGN || code == A_OFF);
            end
            if (code == prev_code) code = (prev_code == A_OFF) ? A_MAG : A_OFF;

            r = $urandom_range(0, 9);
            if (code == A_MAG)
                g = (r <= 8) ? mag_tab[r] : 7'($urandom());
            else if (code == A_SIGN)
                g = (r <= 4) ? 7'b0111111 : (r <= 8) ? 7'b1111111 : 7'($urandom());
            else
                g = 7'($urandom());
            dur = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 10) : $urandom_range(25, 50);

            if (code != A_MAG && code != A_SIGN && code != A_OFF) begin
                exp_q.push_back('{is_err: 1'b1, val: cur_val});
                m_hm = 0; m_hs = 0;
            end else if (code != A_OFF && dur >= SETTLE + 1) begin
                m = (code == A_MAG) ? mag_of(g) : -1;
                if ((code == A_MAG && m < 0) ||
                    (code == A_SIGN && g != 7'b0111111 && g != 7'b1111111)) begin
                    exp_q.push_back('{is_err: 1'b1, val: cur_val});
                    m_hm = 0; m_hs = 0;
                end else begin
                    if (code == A_MAG) begin m_mag = m; m_hm = 1; end
                    else begin m_minus = (g == 7'b0111111); m_hs = 1; end
                    if (m_hm && m_hs) begin
                        m_hm = 0; m_hs = 0;
                        if (m_minus ? (m_mag >= 1 && m_mag <= 8) : (m_mag <= 7)) begin
                            cur_val = 4'(m_minus ? (16 - m_mag) % 16 : m_mag);
                            exp_q.push_back('{is_err: 1'b0, val: cur_val});
                        end else begin
                            exp_q.push_back('{is_err: 1'b1, val: cur_val});
                        end
                    end
                end
            end
            dwell(code, g, dur);
            prev_code = code;
        end
        dwell(A_OFF, 7'h7F, 30);

        chk("rand_count", obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk($sformatf("rand%0d_kind", i), {31'd0, obs[i].is_err}, {31'd0, exp_q[i].is_err});
            chk($sformatf("rand%0d_value", i), {28'd0, obs[i].val}, {28'd0, exp_q[i].val});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
